// File: rtl/mul_pipe_pkg.sv
// Shared constants and the {valid, id} tag type used by the multiplier arbiter.
package mul_pipe_pkg;

    localparam int unsigned MUL_LATENCY = 7;
    localparam int unsigned WIDTH       = 32;
    localparam int unsigned PROD_W      = 2 * WIDTH;
    localparam int unsigned NUM_REQ     = 4;
    localparam int unsigned ID_W        = $clog2(NUM_REQ);
    // Wide enough for the largest supported requester count (16).
    localparam int unsigned MAX_ID_W    = 4;

    typedef struct packed {
        logic                v;
        logic [MAX_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/mul_pipe_32_bit.sv
// Non-stallable, fully pipelined unsigned multiplier: operands captured on one edge,
// registered product available Latency cycles after the capture cycle.
module mul_pipe_32_bit
    import mul_pipe_pkg::*;
#(
    parameter int unsigned Width   = WIDTH,
    parameter int unsigned Latency = MUL_LATENCY
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [Width-1:0]   a_i,
    input  logic [Width-1:0]   b_i,
    output logic [2*Width-1:0] p_o
);

    logic [Width-1:0]   a_q;
    logic [Width-1:0]   b_q;
    // Operand stage plus Latency-1 product stages gives exactly Latency registers.
    logic [2*Width-1:0] prod_q [Latency-1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q <= '0;
            b_q <= '0;
            for (int unsigned k = 0; k < Latency - 1; k++) begin
                prod_q[k] <= '0;
            end
        end else begin
            a_q       <= a_i;
            b_q       <= b_i;
            prod_q[0] <= (2 * Width)'(a_q) * (2 * Width)'(b_q);
            for (int unsigned k = 1; k < Latency - 1; k++) begin
                prod_q[k] <= prod_q[k-1];
            end
        end
    end

    assign p_o = prod_q[Latency-2];

endmodule

// File: rtl/mul_pipe_arbiter.sv
// Round-robin arbiter sharing one pipelined multiplier between NumReq clients; a {v,id}
// tag pipe travels alongside the datapath so each product returns to its owner.
module mul_pipe_arbiter
    import mul_pipe_pkg::*;
#(
    parameter int unsigned NumReq     = NUM_REQ,
    parameter int unsigned Width      = WIDTH,
    parameter int unsigned MulLatency = MUL_LATENCY,
    localparam int unsigned IdW       = (NumReq > 1) ? $clog2(NumReq) : 1,
    localparam int unsigned CntW      = $clog2(MulLatency + 1)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [NumReq-1:0]       req_valid_i,
    input  logic [NumReq*Width-1:0] req_a_i,
    input  logic [NumReq*Width-1:0] req_b_i,
    output logic [NumReq-1:0]       req_ready_o,
    input  logic                    hold_i,
    output logic [NumReq-1:0]       rsp_valid_o,
    output logic [2*Width-1:0]      rsp_data_o,
    output logic [CntW-1:0]         inflight_o
);

    logic [IdW-1:0]   ptr_q, ptr_d;
    logic [IdW-1:0]   winner;
    logic             any_valid;
    logic             transfer;
    logic             rsp_fire;
    int unsigned      idx;
    logic [Width-1:0] mul_a, mul_b;
    logic [CntW-1:0]  inflight_q, inflight_d;
    tag_t             tag_q [MulLatency];

    // Scan upward from the pointer, wrapping; first valid requester wins.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            idx = (32'(ptr_q) + k) % NumReq;
            if (!any_valid && |(req_valid_i & (NumReq'(1) << idx))) begin
                any_valid = 1'b1;
                winner    = IdW'(idx);
            end
        end
    end

    // The winner is always valid, so a grant is always a transfer.
    assign transfer    = any_valid && !hold_i && !reset_i;
    assign req_ready_o = transfer ? (NumReq'(1) << winner) : '0;

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        ptr_d = ptr_q;
        if (transfer) begin
            mul_a = req_a_i[32'(winner)*Width +: Width];
            mul_b = req_b_i[32'(winner)*Width +: Width];
            ptr_d = (winner == IdW'(NumReq - 1)) ? '0 : winner + 1'b1;
        end
    end

    assign rsp_fire    = tag_q[MulLatency-1].v;
    assign rsp_valid_o = rsp_fire ? (NumReq'(1) << tag_q[MulLatency-1].id) : '0;
    assign inflight_d  = inflight_q + CntW'(transfer) - CntW'(rsp_fire);
    assign inflight_o  = inflight_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ptr_q      <= '0;
            inflight_q <= '0;
            for (int unsigned k = 0; k < MulLatency; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            ptr_q      <= ptr_d;
            inflight_q <= inflight_d;
            tag_q[0]   <= '{v: transfer, id: MAX_ID_W'(winner)};
            for (int unsigned k = 1; k < MulLatency; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    mul_pipe_32_bit #(
        .Width   (Width),
        .Latency (MulLatency)
    ) u_mul (
        .clk_i (clk_i),
        .rst_i (reset_i),
        .a_i   (mul_a),
        .b_i   (mul_b),
        .p_o   (rsp_data_o)
    );

endmodule

// File: tb/tb_mul_pipe_arbiter.sv
// Directed and randomised checks of mul_pipe_arbiter against hand values and a cycle model.
module tb_mul_pipe_arbiter;

    logic         clk;
    logic         rst;
    logic [3:0]   req_valid;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [3:0]   req_ready;
    logic         hold;
    logic [3:0]   rsp_valid;
    logic [63:0]  rsp_data;
    logic [2:0]   inflight;

    mul_pipe_arbiter u_dut (
        .clk_i       (clk),
        .reset_i     (rst),
        .req_valid_i (req_valid),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .req_ready_o (req_ready),
        .hold_i      (hold),
        .rsp_valid_o (rsp_valid),
        .rsp_data_o  (rsp_data),
        .inflight_o  (inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [3:0] GRANT_TBL [16] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd1, 4'd2, 4'd4, 4'd8,
                                             4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd4, 4'd8, 4'd1};
    localparam logic [63:0] DATA_TBL [16] = '{64'd6, 64'd9, 64'd12, 64'd15, 64'd6, 64'd9,
                                             64'd12, 64'd15, 64'd0, 64'd0, 64'd0, 64'd6,
                                             64'd9, 64'd12, 64'd15, 64'd6};

    int n_chk;
    int n_pass;
    int cyc;
    int m_ptr;
    int m_infl;
    bit          hv    [16];
    int          hid   [16];
    logic [63:0] hprod [16];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [3:0] model_grant(logic [3:0] v, int p, logic h, logic r);
        logic [3:0] g;
        g = 4'b0;
        if (!h && !r) begin
            for (int k = 0; k < 4; k++) begin
                int i;
                i = (p + k) % 4;
                if (g == 4'b0 && v[i]) g = 4'(1 << i);
            end
        end
        return g;
    endfunction

    // One clock cycle: mid-cycle checks against the model, then advance to just after the edge.
    task automatic step();
        logic [3:0] g;
        logic [3:0] ev;
        int s, c, gi;
        @(negedge clk);
        g = model_grant(req_valid, m_ptr, hold, rst);
        check("req_ready", 64'(req_ready), 64'(g));
        s  = (cyc + 16 - 7) % 16;
        ev = hv[s] ? 4'(1 << hid[s]) : 4'b0;
        check("rsp_valid", 64'(rsp_valid), 64'(ev));
        if (hv[s]) check("rsp_data", rsp_data, hprod[s]);
        check("inflight", 64'(inflight), 64'(m_infl));
        gi = -1;
        for (int k = 0; k < 4; k++) if (g[k]) gi = k;
        c = cyc % 16;
        hv[c]    = (gi >= 0);
        hid[c]   = gi;
        hprod[c] = (gi >= 0) ? 64'(req_a[gi*32 +: 32]) * 64'(req_b[gi*32 +: 32]) : 64'd0;
        m_infl   = m_infl + int'(gi >= 0) - int'(hv[s]);
        if (gi >= 0) m_ptr = (gi + 1) % 4;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_data", rsp_data, 64'd0);
        check("rst_inflight", 64'(inflight), 64'd0);
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < 16; k++) hv[k] = 1'b0;
        m_ptr  = 0;
        m_infl = 0;
        rst    = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        req_valid[i]      = 1'b1;
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
    endtask

    initial begin
        n_chk = 0; n_pass = 0; cyc = 0; m_ptr = 0; m_infl = 0;
        for (int k = 0; k < 16; k++) begin
            hv[k] = 1'b0; hid[k] = 0; hprod[k] = 64'd0;
        end
        req_valid = 4'b0; req_a = '0; req_b = '0; hold = 1'b0; rst = 1'b0;
        do_reset();

        // Single op: 3*5 to requester 0.
        set_req(0, 32'd3, 32'd5);
        step();
        req_valid = 4'b0;
        check("t1_inflight_busy", 64'(inflight), 64'd1);
        repeat (6) step();
        check("t1_rsp_valid", 64'(rsp_valid), 64'h1);
        check("t1_rsp_data", rsp_data, 64'd15);
        check("t1_inflight_last", 64'(inflight), 64'd1);
        step();
        check("t1_inflight_done", 64'(inflight), 64'd0);
        check("t1_rsp_gone", 64'(rsp_valid), 64'd0);

        // Extremes: all-ones squared, then a zero operand.
        set_req(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step();
        req_valid = 4'b0;
        set_req(2, 32'd0, 32'h1234_5678);
        step();
        req_valid = 4'b0;
        repeat (5) step();
        check("t3_max_valid", 64'(rsp_valid), 64'h2);
        check("t3_max_data", rsp_data, 64'hFFFF_FFFE_0000_0001);
        step();
        check("t3_zero_valid", 64'(rsp_valid), 64'h4);
        check("t3_zero_data", rsp_data, 64'd0);

        // Reset with five operations in flight.
        for (int i = 0; i < 4; i++) set_req(i, 32'(i + 7), 32'd9);
        repeat (5) step();
        check("t5_inflight", 64'(inflight), 64'd5);
        do_reset();
        req_valid = 4'b0;
        repeat (10) step();
        check("t5_quiet", 64'(inflight), 64'd0);

        // Continuous four-way streaming from ptr 0 with a 3-cycle hold.
        for (int i = 0; i < 4; i++) set_req(i, 32'(i + 2), 32'd3);
        for (int k = 0; k < 23; k++) begin
            if (k < 16) hold = (k >= 8 && k <= 10);
            else begin
                req_valid = 4'b0;
                hold      = 1'b0;
            end
            #1;
            if (k < 16) check("t2_grant", 64'(req_ready), 64'(GRANT_TBL[k]));
            if (k >= 7) begin
                check("t2_rsp_valid", 64'(rsp_valid), 64'(GRANT_TBL[k-7]));
                if (GRANT_TBL[k-7] != 4'b0) check("t2_rsp_data", rsp_data, DATA_TBL[k-7]);
            end
            step();
        end
        repeat (2) step();
        check("t2_drained", 64'(inflight), 64'd0);

        // Random valid/hold traffic against the model.
        for (int k = 0; k < 2000; k++) begin
            req_valid = 4'($urandom);
            hold      = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 4; i++) begin
                req_a[i*32 +: 32] = $urandom;
                req_b[i*32 +: 32] = $urandom;
            end
            step();
        end
        req_valid = 4'b0;
        hold      = 1'b0;
        repeat (9) step();
        check("t6_drained", 64'(inflight), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
